// File: rtl/rv32i_types.sv
// Shared core types: physical register count and the tag/arch-register typedefs
// used by the rename and retirement tables.
package rv32i_types;
    localparam int NUM_REGS = 64;
    localparam int PHYS_W   = $clog2(NUM_REGS);
    localparam int NUM_ARCH = 32;

    typedef logic [PHYS_W-1:0] phys_tag_t;
    typedef logic [4:0]        arch_reg_t;
endpackage

// File: rtl/retirement_rat_if.sv
// Commit / free-return / flush-snapshot bundle between ROB, retirement RAT,
// free list and front-end RAT.
interface retirement_rat_if
    import rv32i_types::*;
;
    logic        commit_valid;
    arch_reg_t   commit_arch_rd;
    phys_tag_t   commit_phys_rd;
    logic        flush_in;
    phys_tag_t   rrf_arch_to_physical [NUM_ARCH];
    logic        reg_freed;
    phys_tag_t   liberated_reg;
    logic        flush_out;
    logic [31:0] commit_count;

    modport master (
        output commit_valid, commit_arch_rd, commit_phys_rd, flush_in,
        input  rrf_arch_to_physical, reg_freed, liberated_reg, flush_out, commit_count
    );

    modport slave (
        input  commit_valid, commit_arch_rd, commit_phys_rd, flush_in,
        output rrf_arch_to_physical, reg_freed, liberated_reg, flush_out, commit_count
    );
endinterface

// File: rtl/retirement_rat.sv
// Retirement register alias table: records committed arch->phys mappings, returns
// the displaced tag to the free list and re-times flush so the snapshot includes it.
module retirement_rat
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           swap_pc,
    retirement_rat_if.slave rat
);
    phys_tag_t map_q [1:NUM_ARCH-1];
    phys_tag_t old_map;
    logic      commit_en;
    logic      write_en;
    logic      free_en;
    logic      map_unique;

    // x0 is hardwired to tag 0, so only entries 1..31 are flops.
    always_comb begin
        rat.rrf_arch_to_physical[0] = '0;
        for (int i = 1; i < NUM_ARCH; i++) begin
            rat.rrf_arch_to_physical[i] = map_q[i];
        end
    end

    assign old_map   = rat.rrf_arch_to_physical[rat.commit_arch_rd];
    assign commit_en = rat.commit_valid && !rat.flush_out;
    assign write_en  = commit_en && (rat.commit_arch_rd != '0);
    assign free_en   = write_en && (old_map != '0) && (old_map != rat.commit_phys_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_ARCH; i++) begin
                map_q[i] <= phys_tag_t'(i);
            end
        end else if (swap_pc) begin
            for (int i = 1; i < NUM_ARCH; i++) begin
                map_q[i] <= phys_tag_t'(i);
            end
        end else begin
            for (int i = 1; i < NUM_ARCH; i++) begin
                if (write_en && (rat.commit_arch_rd == arch_reg_t'(i))) begin
                    map_q[i] <= rat.commit_phys_rd;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rat.reg_freed     <= 1'b0;
            rat.liberated_reg <= '0;
            rat.flush_out     <= 1'b0;
            rat.commit_count  <= '0;
        end else if (swap_pc) begin
            rat.reg_freed     <= 1'b0;
            rat.liberated_reg <= '0;
            rat.flush_out     <= 1'b0;
            rat.commit_count  <= '0;
        end else begin
            rat.reg_freed <= free_en;
            if (free_en) begin
                rat.liberated_reg <= old_map;
            end
            rat.flush_out <= rat.flush_in;
            if (commit_en) begin
                rat.commit_count <= rat.commit_count + 32'd1;
            end
        end
    end

    always_comb begin
        map_unique = 1'b1;
        for (int i = 1; i < NUM_ARCH; i++) begin
            for (int j = i + 1; j < NUM_ARCH; j++) begin
                if (map_q[i] == map_q[j]) begin
                    map_unique = 1'b0;
                end
            end
        end
    end

    a_map_unique: assert property (@(posedge clk) disable iff (!rst_n) map_unique);

    // The ROB is empty while the flush snapshot is being consumed.
    a_no_commit_during_flush: assert property (
        @(posedge clk) disable iff (!rst_n) !(rat.flush_out && rat.commit_valid));
endmodule

// File: tb/tb_retirement_rat.sv
// Scoreboard bench for retirement_rat: directed scenarios then random commits
// against an array/free-pool reference model.
module tb_retirement_rat;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic swap_pc = 1'b0;

    retirement_rat_if rif();

    retirement_rat dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .swap_pc (swap_pc),
        .rat     (rif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int           due;
        bit           freed;
        bit           chk_lib;
        logic [5:0]   lib;
        bit           fl;
        logic [31:0]  cnt;
        logic [191:0] map;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_map[32];
    logic [31:0] m_cnt;
    bit          m_fl_out;
    int          m_pool[$];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = i;
        m_cnt    = 32'd0;
        m_fl_out = 1'b0;
        m_pool.delete();
        for (int t = 32; t < 64; t++) m_pool.push_back(t);
    endfunction

    function automatic logic [191:0] pack_model();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*6 +: 6] = 6'(m_map[i]);
        return r;
    endfunction

    function automatic logic [191:0] pack_dut();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*6 +: 6] = rif.rrf_arch_to_physical[i];
        return r;
    endfunction

    function automatic void chk(string nm, logic [191:0] act, logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void pool_remove(int t);
        for (int k = 0; k < m_pool.size(); k++) begin
            if (m_pool[k] == t) begin
                m_pool.delete(k);
                return;
            end
        end
    endfunction

    task automatic step(input bit v, input int rd, input int pd, input bit fl, input bit sw);
        exp_t e;
        int   old;
        @(posedge clk);
        #1;
        rif.commit_valid   = v;
        rif.commit_arch_rd = 5'(rd);
        rif.commit_phys_rd = 6'(pd);
        rif.flush_in       = fl;
        swap_pc            = sw;
        e     = '0;
        e.due = cyc + 1;
        if (sw) begin
            model_reset();
            e.chk_lib = 1'b1;
            e.lib     = 6'd0;
        end else begin
            if (v && !m_fl_out) begin
                m_cnt = m_cnt + 32'd1;
                if (rd != 0) begin
                    old = m_map[rd];
                    if (old != pd) begin
                        pool_remove(pd);
                        if (old != 0) begin
                            e.freed   = 1'b1;
                            e.chk_lib = 1'b1;
                            e.lib     = 6'(old);
                            m_pool.push_back(old);
                        end
                    end
                    m_map[rd] = pd;
                end
            end
            m_fl_out = fl;
        end
        e.fl  = m_fl_out;
        e.cnt = m_cnt;
        e.map = pack_model();
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("map", pack_dut(), e.map);
                chk("reg_freed", 192'(rif.reg_freed), 192'(e.freed));
                if (e.chk_lib) chk("liberated_reg", 192'(rif.liberated_reg), 192'(e.lib));
                chk("flush_out", 192'(rif.flush_out), 192'(e.fl));
                chk("commit_count", 192'(rif.commit_count), 192'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        bit v, fl, sw;
        int rd, pd, w;
        rif.commit_valid   = 1'b0;
        rif.commit_arch_rd = '0;
        rif.commit_phys_rd = '0;
        rif.flush_in       = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_map", pack_dut(), pack_model());
        chk("rst_reg_freed", 192'(rif.reg_freed), 192'(0));
        chk("rst_liberated", 192'(rif.liberated_reg), 192'(0));
        chk("rst_flush_out", 192'(rif.flush_out), 192'(0));
        chk("rst_count", 192'(rif.commit_count), 192'(0));
        #2 rst_n = 1'b1;
        #1;
        chk("rel_map", pack_dut(), pack_model());
        chk("rel_reg_freed", 192'(rif.reg_freed), 192'(0));
        chk("rel_flush_out", 192'(rif.flush_out), 192'(0));

        step(1, 5, 40, 0, 0);
        step(1, 5, 41, 0, 0);
        step(1, 0, 33, 0, 0);
        step(1, 7, 7, 0, 0);
        step(1, 3, 50, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 12, 33, 0, 0);
        step(1, 9, 60, 0, 1);
        step(0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            sw = ($urandom % 64) == 0;
            fl = ($urandom % 8) == 0;
            v  = !m_fl_out && (($urandom % 4) != 0);
            rd = int'($urandom % 32);
            if (rd == 0) pd = int'($urandom % 64);
            else if (($urandom % 8) == 0) pd = m_map[rd];
            else pd = m_pool[$urandom % m_pool.size()];
            step(v, rd, pd, fl, sw);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        w = 0;
        while (sbq.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
